// File: rtl/bus_xcvr_n_if.sv
// Control/status bundle for bus_xcvr_n.
//   DIR  : per-lane direction, 1 = A->B (drive B), 0 = B->A (drive A)
//   _CS  : per-lane active-low enable
//   OE_A : lane currently drives its A bus
//   OE_B : lane currently drives its B bus
//   TURN : lane is in its hi-Z turnaround gap
// The A/B data buses are inout nets and stay plain ports on the block so
// that tristate resolution happens on ordinary module-level wires.
interface bus_xcvr_n_if #(parameter int CHANNELS = 2);
  logic [CHANNELS-1:0] DIR;
  logic [CHANNELS-1:0] _CS;
  logic [CHANNELS-1:0] OE_A;
  logic [CHANNELS-1:0] OE_B;
  logic [CHANNELS-1:0] TURN;

  modport master (output DIR, output _CS, input OE_A, input OE_B, input TURN);
  modport slave  (input DIR, input _CS, output OE_A, output OE_B, output TURN);
endinterface

// File: rtl/bus_xcvr_n.sv
// Multi-channel clocked bidirectional bus transceiver.
// Each lane links WIDTH-bit A and B buses. A per-lane FSM (IDLE/DRV_A/DRV_B/
// GAP) guarantees TURN_CYCLES hi-Z cycles on every direction reversal, so
// both sides of a lane are never driven together.
// Ports:
//   CLK    : clock, rising edge
//   _RESET : asynchronous active-low reset, releases all buses at once
//   ctl    : DIR/_CS in, OE_A/OE_B/TURN out (bus_xcvr_n_if.slave)
//   A, B   : inout buses, lane i at [i*WIDTH +: WIDTH]
// TURN_CYCLES must be in 1..15 (fits the 4-bit gap counter).

module bus_xcvr_n_lane #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int REG_DATA    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dir,
  input  logic             cs_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_drv,
  output logic [WIDTH-1:0] b_drv,
  output logic             oe_a,
  output logic             oe_b,
  output logic             turn
);
  typedef enum logic [1:0] {IDLE, DRV_A, DRV_B, GAP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(TURN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (!cs_n) state_nxt = dir ? DRV_B : DRV_A;
      DRV_A: begin
        if (cs_n)     state_nxt = IDLE;
        else if (dir) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_LOAD;
        end
      end
      DRV_B: begin
        if (cs_n)      state_nxt = IDLE;
        else if (!dir) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_LOAD;
        end
      end
      GAP: begin
        // disable wins over gap expiry; DIR only matters on the exit edge
        if (cs_n)              state_nxt = IDLE;
        else if (cnt == 4'd0)  state_nxt = dir ? DRV_B : DRV_A;
        else                   cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign oe_a = (state == DRV_A);
  assign oe_b = (state == DRV_B);
  assign turn = (state == GAP);

  if (REG_DATA != 0) begin : g_reg
    // Free-running capture; only the copy for the driven side is ever
    // put on a bus, so no enable is needed.
    logic [WIDTH-1:0] da, db;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        da <= '0;
        db <= '0;
      end else begin
        da <= b_in;
        db <= a_in;
      end
    end
    assign a_drv = da;
    assign b_drv = db;
  end else begin : g_comb
    assign a_drv = b_in;
    assign b_drv = a_in;
  end
endmodule

module bus_xcvr_n #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int TURN_CYCLES = 1,
  parameter int REG_DATA    = 1
) (
  input  logic                      CLK,
  input  logic                      _RESET,
  bus_xcvr_n_if.slave               ctl,
  inout  wire  [CHANNELS*WIDTH-1:0] A,
  inout  wire  [CHANNELS*WIDTH-1:0] B
);
  logic [CHANNELS-1:0][WIDTH-1:0] a_drv, b_drv;
  logic [CHANNELS-1:0]            oe_a, oe_b, turn;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    bus_xcvr_n_lane #(
      .WIDTH(WIDTH), .TURN_CYCLES(TURN_CYCLES), .REG_DATA(REG_DATA)
    ) u_lane (
      .clk  (CLK),
      .rst_n(_RESET),
      .dir  (ctl.DIR[i]),
      .cs_n (ctl._CS[i]),
      .a_in (A[i*WIDTH +: WIDTH]),
      .b_in (B[i*WIDTH +: WIDTH]),
      .a_drv(a_drv[i]),
      .b_drv(b_drv[i]),
      .oe_a (oe_a[i]),
      .oe_b (oe_b[i]),
      .turn (turn[i])
    );
    // drivers gated by the state-register decodes, so async reset
    // releases the buses without waiting for a clock
    assign A[i*WIDTH +: WIDTH] = oe_a[i] ? a_drv[i] : {WIDTH{1'bz}};
    assign B[i*WIDTH +: WIDTH] = oe_b[i] ? b_drv[i] : {WIDTH{1'bz}};
  end

  assign ctl.OE_A = oe_a;
  assign ctl.OE_B = oe_b;
  assign ctl.TURN = turn;
endmodule

// File: tb/tb_bus_xcvr_n.sv
module tb_bus_xcvr_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // u0: 2 lanes, TURN_CYCLES=2, registered data
  logic rst0_n;
  bus_xcvr_n_if #(.CHANNELS(2)) ifc0 ();
  wire  [15:0] a0, b0;
  logic [1:0]  a0_en, b0_en;
  logic [15:0] a0_val, b0_val;
  for (genvar i = 0; i < 2; i++) begin : g_tb0
    assign a0[i*8 +: 8] = a0_en[i] ? a0_val[i*8 +: 8] : 8'hzz;
    assign b0[i*8 +: 8] = b0_en[i] ? b0_val[i*8 +: 8] : 8'hzz;
  end
  bus_xcvr_n #(.WIDTH(8), .CHANNELS(2), .TURN_CYCLES(2), .REG_DATA(1)) u0 (
    .CLK(clk), ._RESET(rst0_n), .ctl(ifc0), .A(a0), .B(b0));

  // u1: 1 lane, TURN_CYCLES=3, combinational data
  logic rst1_n;
  bus_xcvr_n_if #(.CHANNELS(1)) ifc1 ();
  wire  [7:0] a1, b1;
  logic       a1_en;
  logic [7:0] a1_val;
  assign a1 = a1_en ? a1_val : 8'hzz;
  bus_xcvr_n #(.WIDTH(8), .CHANNELS(1), .TURN_CYCLES(3), .REG_DATA(0)) u1 (
    .CLK(clk), ._RESET(rst1_n), .ctl(ifc1), .A(a1), .B(b1));

  typedef struct {
    logic [1:0]  cs, dir, aen, ben;
    logic [15:0] a, b;
    logic [1:0]  eoa, eob, etu;
    logic [15:0] ea, eb;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          cs     dir    aen    ben    a        b        eoa    eob    etu    ea       eb
    for (int k = 0; k < 5; k++)
      vt[k] = '{2'b11, 2'b00, 2'b01, 2'b00, 16'h005A, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0};
    vt[5]  = '{2'b10, 2'b01, 2'b01, 2'b00, 16'h003C, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h0,    16'h003C};
    vt[6]  = '{2'b10, 2'b01, 2'b01, 2'b00, 16'h00C3, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h0,    16'h00C3};
    vt[7]  = '{2'b00, 2'b01, 2'b01, 2'b10, 16'h00AA, 16'h5500, 2'b10, 2'b01, 2'b00, 16'h5500, 16'h00AA};
    vt[8]  = '{2'b00, 2'b01, 2'b01, 2'b10, 16'h00AA, 16'h5500, 2'b10, 2'b01, 2'b00, 16'h5500, 16'h00AA};
    vt[9]  = '{2'b00, 2'b11, 2'b01, 2'b10, 16'h00AA, 16'h5500, 2'b00, 2'b01, 2'b10, 16'h0,    16'h00AA};
    vt[10] = '{2'b00, 2'b11, 2'b11, 2'b00, 16'h66AA, 16'h0000, 2'b00, 2'b01, 2'b10, 16'h0,    16'h00AA};
    vt[11] = '{2'b00, 2'b11, 2'b11, 2'b00, 16'h77AA, 16'h0000, 2'b00, 2'b11, 2'b00, 16'h0,    16'h77AA};
    vt[12] = '{2'b00, 2'b10, 2'b11, 2'b00, 16'h77AA, 16'h0000, 2'b00, 2'b10, 2'b01, 16'h0,    16'h7700};
    vt[13] = '{2'b00, 2'b11, 2'b10, 2'b01, 16'h7700, 16'h0099, 2'b00, 2'b10, 2'b01, 16'h0,    16'h7700};
    vt[14] = '{2'b00, 2'b10, 2'b10, 2'b01, 16'h7700, 16'h0099, 2'b01, 2'b10, 2'b00, 16'h0099, 16'h7700};
    vt[15] = '{2'b01, 2'b11, 2'b10, 2'b01, 16'h7700, 16'h0099, 2'b00, 2'b10, 2'b00, 16'h0,    16'h7700};
    vt[16] = '{2'b11, 2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0,    16'h0};

    rst0_n = 1'b0; rst1_n = 1'b0;
    ifc0._CS = 2'b11; ifc0.DIR = 2'b00;
    a0_en = 2'b01; a0_val = 16'h005A; b0_en = 2'b00; b0_val = 16'h0;
    ifc1._CS = 1'b1; ifc1.DIR = 1'b0;
    a1_en = 1'b1; a1_val = 8'h5A;

    // reset held across clocks: everything released
    repeat (3) step();
    chk("rst_oe_a", 32'(ifc0.OE_A), 32'h0);
    chk("rst_oe_b", 32'(ifc0.OE_B), 32'h0);
    chk("rst_turn", 32'(ifc0.TURN), 32'h0);
    chk("rst1_oe_b", 32'(ifc1.OE_B), 32'h0);

    rst0_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      ifc0._CS = vt[k].cs;  ifc0.DIR = vt[k].dir;
      a0_en = vt[k].aen;    a0_val = vt[k].a;
      b0_en = vt[k].ben;    b0_val = vt[k].b;
      step();
      chk($sformatf("v%0d_oe_a", k), 32'(ifc0.OE_A), 32'(vt[k].eoa));
      chk($sformatf("v%0d_oe_b", k), 32'(ifc0.OE_B), 32'(vt[k].eob));
      chk($sformatf("v%0d_turn", k), 32'(ifc0.TURN), 32'(vt[k].etu));
      chk($sformatf("v%0d_excl", k), 32'(ifc0.OE_A & ifc0.OE_B), 32'h0);
      for (int l = 0; l < 2; l++) begin
        if (vt[k].eoa[l]) chk($sformatf("v%0d_a%0d", k, l), 32'(a0[l*8 +: 8]), 32'(vt[k].ea[l*8 +: 8]));
        if (vt[k].eob[l]) chk($sformatf("v%0d_b%0d", k, l), 32'(b0[l*8 +: 8]), 32'(vt[k].eb[l*8 +: 8]));
      end
    end

    // u1: combinational pass-through, then abort inside the gap
    rst1_n = 1'b1;
    ifc1._CS = 1'b0; ifc1.DIR = 1'b1; a1_val = 8'h11;
    step();
    chk("u1_drv_oe_b", 32'(ifc1.OE_B), 32'h1);
    chk("u1_drv_b", 32'(b1), 32'h11);
    a1_val = 8'h22;
    #1;
    chk("u1_comb_b", 32'(b1), 32'h22);
    ifc1.DIR = 1'b0;
    step();
    chk("u1_gap_turn", 32'(ifc1.TURN), 32'h1);
    chk("u1_gap_oe", 32'({ifc1.OE_A, ifc1.OE_B}), 32'h0);
    ifc1._CS = 1'b1;
    step();
    chk("u1_abort_turn", 32'(ifc1.TURN), 32'h0);
    chk("u1_abort_oe", 32'({ifc1.OE_A, ifc1.OE_B}), 32'h0);
    step();
    chk("u1_idle_oe", 32'({ifc1.OE_A, ifc1.OE_B, ifc1.TURN}), 32'h0);

    // u1: async reset mid-drive
    ifc1._CS = 1'b0; ifc1.DIR = 1'b1; a1_val = 8'hFF;
    step();
    chk("u1_ff_oe_b", 32'(ifc1.OE_B), 32'h1);
    chk("u1_ff_b", 32'(b1), 32'hFF);
    @(posedge clk);
    #1;
    chk("u1_pre_rst_oe_b", 32'(ifc1.OE_B), 32'h1);
    #1 rst1_n = 1'b0;
    #1;
    chk("u1_async_oe_b", 32'(ifc1.OE_B), 32'h0);
    chk("u1_async_turn", 32'(ifc1.TURN), 32'h0);
    @(negedge clk);
    ifc1._CS = 1'b1; rst1_n = 1'b1;
    step();
    chk("u1_post_rst_oe_b", 32'(ifc1.OE_B), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_xcvr_n.md
# bus_xcvr_n

Parametrised, clocked multi-channel bidirectional bus transceiver: the successor to the dual 8-bit DIR/_CS buffer pair. Each of CHANNELS independent lanes connects an A-side and a B-side WIDTH-bit bus. Direction and enable are controlled per lane by DIR/_CS, and a per-lane state machine inserts a guaranteed hi-Z turnaround on every direction reversal so the two sides are never driven at once. An optional data register stage breaks the combinational A↔B path for timing closure on the backplane.

## Interface

Parameters:
- WIDTH, 8, bits per lane.
- CHANNELS, 2, number of independent lanes.
- TURN_CYCLES, 1, hi-Z cycles inserted on a direction change; legal range 1..15.
- REG_DATA, 1. 1 = driven side outputs a registered copy of the source side (1-cycle latency). 0 = combinational pass-through while driving.

Ports:
- CLK, in, 1, system clock; all sampling on the rising edge.
- _RESET, in, 1, asynchronous active-low reset.
- DIR, in, CHANNELS, per-lane direction. 1 = A→B (block drives B). 0 = B→A (block drives A).
- _CS, in, CHANNELS, per-lane active-low enable.
- A, inout, CHANNELS*WIDTH, A-side buses; lane i occupies bits [i*WIDTH +: WIDTH].
- B, inout, CHANNELS*WIDTH, B-side buses; same packing as A.
- OE_A, out, CHANNELS, 1 = block currently drives A of that lane.
- OE_B, out, CHANNELS, 1 = block currently drives B of that lane.
- TURN, out, CHANNELS, 1 = lane is in its turnaround gap.

## Operation

- Per-lane FSM states:
  - IDLE: both sides hi-Z.
  - DRV_A: A driven from B.
  - DRV_B: B driven from A.
  - GAP: both sides hi-Z; 4-bit down-counter running.
- OE_A = (state==DRV_A), OE_B = (state==DRV_B), TURN = (state==GAP); all are registered state decodes. Exactly one of IDLE/DRV_A/DRV_B/GAP holds per lane, so OE_A & OE_B is never 1.
- Transitions, evaluated at each rising CLK on the sampled DIR/_CS:
  - IDLE: _CS=0 → DRV_A if DIR=0, DRV_B if DIR=1; else stay in IDLE.
  - DRV_A/DRV_B: _CS=1 → IDLE. _CS=0 with DIR mismatching the current state → GAP, counter loaded with TURN_CYCLES-1. Otherwise hold.
  - GAP: _CS=1 → IDLE (takes priority over the counter). Counter=0 → DRV_A/DRV_B per DIR sampled at that edge. Otherwise decrement.
  - DIR toggling inside GAP does not restart the gap; only DIR at gap exit matters.
- IDLE→DRV has no gap, because the lane is already released.
- Data, REG_DATA=1: per lane, register DA captures B every edge and register DB captures A every edge. A is driven with DA, B is driven with DB.
- Data, REG_DATA=0: A is driven with B and B is driven with A, combinationally, gated by OE.
- Hi-Z uses all-z of WIDTH bits.
- Lanes share nothing except CLK and _RESET.

## Timing

- Reset (_RESET=0, asynchronous): all lanes go to IDLE. OE_A=OE_B=TURN=0, A/B hi-Z immediately (no clock needed), data registers and counters 0. Deassertion is sampled at the next rising CLK.
- Reset asserted mid-drive or mid-gap releases both buses in the same cycle, asynchronously.
- Enable latency: _CS sampled 0 at edge n → driver on after edge n.
  - REG_DATA=1: first driven value is the source value captured at edge n. Subsequent source changes appear on the driven side 1 cycle later.
- Disable latency: _CS sampled 1 at edge n → hi-Z after edge n.
- Reversal: mismatching DIR sampled at edge n → hi-Z after edge n for exactly TURN_CYCLES cycles. The new side is driven after edge n+TURN_CYCLES, provided _CS stays 0.
- Simultaneous _CS=1 and DIR change at the same edge: go to IDLE, no GAP.

## Test plan

- Reset/idle: hold _RESET=0, drive A=8'h5A externally → B hi-Z, OE_*=0. Release reset with _CS=1 for 5 cycles → still hi-Z.
- Enable A→B, REG_DATA=1, lane 0: _CS=0, DIR=1, A=8'h3C at edge n, then A=8'hC3 at edge n+1 → OE_B=1 after edge n. B=8'h3C in cycle n..n+1, B=8'hC3 after edge n+1. A is never driven.
- Reversal, TURN_CYCLES=2: from DRV_B, flip DIR to 0 at edge n → both sides z and TURN=1 for 2 cycles. OE_A=1 after edge n+2. OE_A&OE_B=0 asserted on every cycle.
- Abort in gap: TURN_CYCLES=3, reverse at edge n, _CS=1 at edge n+1 → IDLE after edge n+1, no side ever driven, TURN=0.
- Lane independence, CHANNELS=2: lane 0 A→B with 8'hAA while lane 1 B→A with 8'h55, then reverse lane 1 only → lane 0 output uninterrupted at 8'hAA.
- Async reset mid-drive, REG_DATA=0: drive B from A=8'hFF, pulse _RESET low between clock edges → B goes z within the same cycle, and OE_B=0 before the next edge.
